// File: rtl/sd_sector_server.sv
// Responder side of the SD sector protocol: moves one 256-word sector between
// the consumer's sector buffer and a word-wide save-storage memory.
module sd_sector_server #(
    parameter int SECT_BITS  = 9,
    parameter int ACK_DELAY  = 2,
    parameter int BUF_RD_LAT = 1
) (
    input  logic                 clk_sys,
    input  logic                 reset_n,
    input  logic [31:0]          sd_lba,
    input  logic                 sd_rd,
    input  logic                 sd_wr,
    output logic                 sd_ack,
    output logic [7:0]           sd_buff_addr,
    output logic [15:0]          sd_buff_dout,
    output logic                 sd_buff_wr,
    input  logic [15:0]          sd_buff_din,
    output logic [SECT_BITS+7:0] st_addr,
    output logic                 st_req,
    output logic                 st_we,
    output logic [15:0]          st_wdata,
    input  logic [15:0]          st_rdata,
    input  logic                 st_ack
);
    typedef enum logic [2:0] {
        IDLE, DELAY, RD_REQ, RD_PUSH, WR_ADDR, WR_WAIT, WR_REQ, FINISH
    } state_t;

    state_t               state;
    logic                 is_rd;
    logic                 oor;
    logic                 ack_q;
    logic [SECT_BITS-1:0] sect;
    logic [7:0]           cnt;
    logic [3:0]           dly;
    logic [1:0]           lat;
    logic                 done;

    // A held-high st_ack counts once; out-of-range sectors never wait on storage.
    assign done = oor | (st_ack & ~ack_q);

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            is_rd        <= 1'b0;
            oor          <= 1'b0;
            ack_q        <= 1'b0;
            sect         <= '0;
            cnt          <= '0;
            dly          <= '0;
            lat          <= '0;
            sd_ack       <= 1'b0;
            sd_buff_addr <= '0;
            sd_buff_dout <= '0;
            sd_buff_wr   <= 1'b0;
            st_addr      <= '0;
            st_req       <= 1'b0;
            st_we        <= 1'b0;
            st_wdata     <= '0;
        end else begin
            ack_q      <= st_ack;
            sd_buff_wr <= 1'b0;
            case (state)
                IDLE: if ((sd_rd | sd_wr) && !sd_ack) begin
                    is_rd <= sd_rd;
                    sect  <= sd_lba[SECT_BITS-1:0];
                    oor   <= (sd_lba >> SECT_BITS) != 32'd0;
                    cnt   <= '0;
                    dly   <= 4'(ACK_DELAY - 1);
                    state <= DELAY;
                end
                DELAY: if (dly == 4'd0) begin
                    sd_ack <= 1'b1;
                    if (is_rd) begin
                        st_req  <= ~oor;
                        st_we   <= 1'b0;
                        st_addr <= {sect, cnt};
                        state   <= RD_REQ;
                    end else begin
                        sd_buff_addr <= cnt;
                        state        <= WR_ADDR;
                    end
                end else begin
                    dly <= dly - 4'd1;
                end
                RD_REQ: if (done) begin
                    st_req       <= 1'b0;
                    sd_buff_wr   <= 1'b1;
                    sd_buff_addr <= cnt;
                    sd_buff_dout <= oor ? 16'h0000 : st_rdata;
                    state        <= RD_PUSH;
                end
                RD_PUSH: if (cnt == 8'hFF) begin
                    sd_ack <= 1'b0;
                    state  <= FINISH;
                end else begin
                    cnt     <= cnt + 8'd1;
                    st_req  <= ~oor;
                    st_addr <= {sect, cnt + 8'd1};
                    state   <= RD_REQ;
                end
                WR_ADDR: if (BUF_RD_LAT == 0) begin
                    st_wdata <= sd_buff_din;
                    st_req   <= ~oor;
                    st_we    <= 1'b1;
                    st_addr  <= {sect, cnt};
                    state    <= WR_REQ;
                end else begin
                    lat   <= 2'(BUF_RD_LAT - 1);
                    state <= WR_WAIT;
                end
                WR_WAIT: if (lat == 2'd0) begin
                    st_wdata <= sd_buff_din;
                    st_req   <= ~oor;
                    st_we    <= 1'b1;
                    st_addr  <= {sect, cnt};
                    state    <= WR_REQ;
                end else begin
                    lat <= lat - 2'd1;
                end
                WR_REQ: if (done) begin
                    st_req <= 1'b0;
                    if (cnt == 8'hFF) begin
                        sd_ack <= 1'b0;
                        state  <= FINISH;
                    end else begin
                        cnt          <= cnt + 8'd1;
                        sd_buff_addr <= cnt + 8'd1;
                        state        <= WR_ADDR;
                    end
                end
                FINISH: begin
                    sd_ack <= 1'b0;
                    st_req <= 1'b0;
                    st_we  <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sd_sector_server.sv
// Bench for sd_sector_server: storage and consumer-buffer models, a vector
// table of sector transfers, a stalled save loop and a mid-write reset.
module tb_sd_sector_server;
    localparam int SB  = 9;
    localparam int AD  = 2;
    localparam int LAT = 1;

    logic          clk_sys = 1'b0;
    logic          reset_n;
    logic [31:0]   sd_lba;
    logic          sd_rd, sd_wr;
    logic          sd_ack;
    logic [7:0]    sd_buff_addr;
    logic [15:0]   sd_buff_dout;
    logic          sd_buff_wr;
    logic [15:0]   sd_buff_din;
    logic [SB+7:0] st_addr;
    logic          st_req, st_we;
    logic [15:0]   st_wdata, st_rdata;
    logic          st_ack;

    sd_sector_server #(.SECT_BITS(SB), .ACK_DELAY(AD), .BUF_RD_LAT(LAT)) dut (
        .clk_sys(clk_sys), .reset_n(reset_n), .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr),
        .sd_ack(sd_ack), .sd_buff_addr(sd_buff_addr), .sd_buff_dout(sd_buff_dout),
        .sd_buff_wr(sd_buff_wr), .sd_buff_din(sd_buff_din), .st_addr(st_addr),
        .st_req(st_req), .st_we(st_we), .st_wdata(st_wdata), .st_rdata(st_rdata),
        .st_ack(st_ack)
    );

    always #5 clk_sys = ~clk_sys;

    logic [15:0] mem   [0:(1<<(SB+8))-1];
    logic [15:0] model [0:(1<<(SB+8))-1];
    logic [15:0] cbuf  [0:255];
    int          max_stall = 0;
    int          wait_left = -1;
    bit          mem_init  = 1'b0;

    // Storage: contents start as address[15:0]; each request stalls 0..max_stall cycles.
    always @(posedge clk_sys) begin
        if (!mem_init) begin
            for (int i = 0; i < (1<<(SB+8)); i++) mem[i] <= 16'(i);
            mem_init <= 1'b1;
            st_ack   <= 1'b0;
            st_rdata <= 16'h0;
        end else if (st_req && !st_ack) begin
            if (wait_left < 0) wait_left <= int'($urandom_range(max_stall, 0));
            else if (wait_left == 0) begin
                st_ack    <= 1'b1;
                wait_left <= -1;
                if (st_we) mem[st_addr] <= st_wdata;
                else       st_rdata     <= mem[st_addr];
            end else wait_left <= wait_left - 1;
        end else begin
            st_ack    <= 1'b0;
            wait_left <= -1;
        end
    end

    always @(posedge clk_sys) sd_buff_din <= cbuf[sd_buff_addr];

    // Monitor: records buffer pushes and storage traffic as running counters.
    logic [7:0]  obs_a [0:4095];
    logic [15:0] obs_d [0:4095];
    int          obs_n = 0, streq_cnt = 0, wr_acks = 0, bad_addr = 0, rises = 0;
    logic        ack_q = 1'b0;
    logic [8:0]  cur_sect = '0;

    always @(negedge clk_sys) begin
        ack_q <= sd_ack;
        if (sd_ack && !ack_q) rises <= rises + 1;
        if (sd_buff_wr) begin
            obs_a[obs_n % 4096] <= sd_buff_addr;
            obs_d[obs_n % 4096] <= sd_buff_dout;
            obs_n <= obs_n + 1;
        end
        if (st_req) begin
            streq_cnt <= streq_cnt + 1;
            if (st_addr[SB+7:8] != cur_sect) bad_addr <= bad_addr + 1;
        end
        if (st_req && st_ack && st_we) wr_acks <= wr_acks + 1;
    end

    typedef struct {
        bit          rd;
        bit          wr;
        logic [31:0] lba;
        int          exp_pulses;
        bit          exp_st;
        int          exp_wacks;
    } vec_t;

    typedef struct packed {
        logic [7:0]  a;
        logic [15:0] d;
    } sb_t;

    sb_t exp_q [$];
    int  n_vec = 0;
    int  n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] pat(input logic [31:0] lba, input int i);
        return {lba[7:0], 8'(i)} ^ 16'h3C3C;
    endfunction

    // Initiator: drop the request on sd_ack rise, return after sd_ack falls.
    task automatic xfer(input bit rd, input bit wr, input logic [31:0] lba, output int lat);
        int n;
        cur_sect = lba[8:0];
        @(negedge clk_sys);
        sd_rd = rd; sd_wr = wr; sd_lba = lba;
        n = 0;
        do begin @(negedge clk_sys); n++; end while (!sd_ack && n < 40);
        lat = sd_ack ? n - 1 : -1;
        sd_rd = 1'b0; sd_wr = 1'b0; sd_lba = $urandom;
        n = 0;
        while (sd_ack && n < 20000) begin @(negedge clk_sys); n++; end
        chk("ack_fall", 64'(sd_ack), 64'd0);
    endtask

    task automatic run_vec(input vec_t v, input bit inv_pat);
        int lat, p0, s0, w0, b0, np, bad;
        logic oor;
        logic [SB+7:0] base;
        sb_t e;
        oor  = v.lba[31:SB] != '0;
        base = {v.lba[SB-1:0], 8'h00};
        if (v.wr && !v.rd)
            for (int i = 0; i < 256; i++) begin
                cbuf[i] = inv_pat ? 16'(~i) : pat(v.lba, i);
                if (!oor) model[base + 17'(i)] = cbuf[i];
            end
        if (v.rd)
            for (int i = 0; i < 256; i++)
                exp_q.push_back(sb_t'({8'(i), oor ? 16'h0000 : model[base + 17'(i)]}));
        p0 = obs_n; s0 = streq_cnt; w0 = wr_acks; b0 = bad_addr;
        xfer(v.rd, v.wr, v.lba, lat);
        repeat (2) @(negedge clk_sys);
        np = obs_n - p0;
        chk("ack_latency", 64'(lat), 64'(AD));
        chk("buff_wr_pulses", 64'(np), 64'(v.exp_pulses));
        chk("st_req_seen", 64'(streq_cnt != s0), 64'(v.exp_st));
        chk("st_write_acks", 64'(wr_acks - w0), 64'(v.exp_wacks));
        chk("st_addr_in_sector", 64'(bad_addr - b0), 64'd0);
        for (int j = 0; j < np && exp_q.size() > 0; j++) begin
            e = exp_q.pop_front();
            chk("pushed_word", 64'({obs_a[(p0 + j) % 4096], obs_d[(p0 + j) % 4096]}), 64'(e));
        end
        exp_q.delete();
        if (v.wr && !v.rd) begin
            bad = 0;
            for (int i = 0; i < 256; i++)
                if (mem[base + 17'(i)] !== model[base + 17'(i)]) bad++;
            chk("sector_content", 64'(bad), 64'd0);
        end
    endtask

    initial begin
        vec_t vecs[6];
        vec_t v;
        int   n, r0, w0;
        vecs[0] = '{1'b1, 1'b0, 32'h0000_0005, 256, 1'b1, 0};
        vecs[1] = '{1'b0, 1'b1, 32'h0000_01FF, 0,   1'b1, 256};
        vecs[2] = '{1'b1, 1'b0, 32'h0000_0200, 256, 1'b0, 0};
        vecs[3] = '{1'b1, 1'b1, 32'h0000_0003, 256, 1'b1, 0};
        vecs[4] = '{1'b0, 1'b1, 32'h8000_0005, 0,   1'b0, 0};
        vecs[5] = '{1'b1, 1'b0, 32'h0000_01FF, 256, 1'b1, 0};

        for (int i = 0; i < (1<<(SB+8)); i++) model[i] = 16'(i);
        reset_n = 1'b0; sd_rd = 1'b0; sd_wr = 1'b0; sd_lba = '0;
        @(posedge clk_sys); #1;
        chk("reset_outputs", 64'({sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr,
                                  st_addr, st_req, st_we, st_wdata}), 64'd0);
        repeat (3) @(negedge clk_sys);
        reset_n = 1'b1;

        for (int k = 0; k < 6; k++) run_vec(vecs[k], k == 1);

        // Save loop with storage stalls: 12 consecutive sectors.
        max_stall = 7;
        r0 = rises; w0 = wr_acks;
        for (int s = 0; s < 12; s++) begin
            v = '{1'b0, 1'b1, 32'(64 + s), 0, 1'b1, 256};
            run_vec(v, 1'b0);
        end
        chk("save_loop_sectors", 64'(rises - r0), 64'd12);
        chk("save_loop_words", 64'(wr_acks - w0), 64'(12 * 256));
        max_stall = 0;

        // Reset at word 100 of a write, then a clean read.
        cur_sect = 9'h007;
        for (int i = 0; i < 256; i++) cbuf[i] = pat(32'h7, i);
        @(negedge clk_sys);
        sd_wr = 1'b1; sd_lba = 32'h7;
        n = 0;
        do begin @(negedge clk_sys); n++; end while (!sd_ack && n < 40);
        sd_wr = 1'b0;
        n = 0;
        while (!(sd_ack && sd_buff_addr == 8'd100) && n < 5000) begin @(negedge clk_sys); n++; end
        chk("reached_word_100", 64'({sd_ack, sd_buff_addr}), 64'({1'b1, 8'd100}));
        reset_n = 1'b0;
        @(posedge clk_sys); #1;
        chk("mid_write_reset", 64'({sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr,
                                    st_addr, st_req, st_we, st_wdata}), 64'd0);
        repeat (2) @(negedge clk_sys);
        reset_n = 1'b1;
        run_vec(vecs[0], 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
